// File: rtl/readout_pkg.sv
// Shared definitions for the T4 readout sequencer and its exposure-side partner.
// Holds the readout state encoding and the default array geometry.
package readout_pkg;

  localparam int NUM_ROW_DEF = 320;
  localparam int ROW_AW_DEF  = 9;
  localparam int CNT_W_DEF   = 32;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ROWSET = 3'd1,
    S_SHR    = 3'd2,
    S_SHS    = 3'd3,
    S_CONV   = 3'd4,
    S_XFER   = 3'd5,
    S_NEXT   = 3'd6,
    S_DONE   = 3'd7
  } ro_state_e;

endpackage

// File: rtl/ro_phase_timer.sv
// Loadable phase down-counter. A load of 0 is clamped to 1, so every phase
// lasts at least one cycle. tc_o is high while the count sits at 1, which is
// the last cycle of the phase that was loaded.
module ro_phase_timer
  import readout_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             tc_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: load with clamp, otherwise count down and park at 1.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = (load_val_i == '0) ? CNT_W'(1) : load_val_i;
    end else if (cnt_q > CNT_W'(1)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= CNT_W'(1);
    else        cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/readout_seq_t4.sv
// T4 row-by-row readout sequencer.
// Accepts the trigger_i / re_busy frame handshake, then per row runs row
// select, reset sample, signal sample, ADC convert and a FIFO hand-off with
// backpressure. All outputs are registered and decoded from the next state.
// Optional feature: define RO_BLACK_ROW_EN to read a black-reference row at
// address NUM_ROW before rows 0..NUM_ROW-1 of every frame.
//
// state    | meaning
// S_IDLE   | waiting for trigger_i, re_busy low
// S_ROWSET | row select settling
// S_SHR    | reset-level sample/hold
// S_SHS    | signal-level sample/hold
// S_CONV   | ADC start on first cycle, then conversion wait
// S_XFER   | wait for FIFO room, then hand the row off
// S_NEXT   | advance row address or finish the frame
// S_DONE   | last readout cycle, row address cleared
module readout_seq_t4
  import readout_pkg::*;
#(
  parameter int NUM_ROW = NUM_ROW_DEF,
  parameter int ROW_AW  = ROW_AW_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic              CLKM,
  input  logic              rst_n,
  input  logic              trigger_i,
  output logic              re_busy,
  output logic [ROW_AW-1:0] RO_ROWADD,
  output logic              ROW_SEL,
  output logic              SH_R,
  output logic              SH_S,
  output logic              ADC_START,
  output logic              row_valid,
  input  logic              fifo_afull,
  input  logic [CNT_W-1:0]  Trow_set,
  input  logic [CNT_W-1:0]  Tshr_w,
  input  logic [CNT_W-1:0]  Tshs_w,
  input  logic [CNT_W-1:0]  Tconv,
  output logic              frame_done
);

  localparam logic [ROW_AW-1:0] LAST_ROW  = ROW_AW'(NUM_ROW - 1);
`ifdef RO_BLACK_ROW_EN
  localparam logic [ROW_AW-1:0] BLACK_ROW = ROW_AW'(NUM_ROW);
`endif

  ro_state_e         state_q, state_d;
  logic [ROW_AW-1:0] rowadd_q, rowadd_d;
  logic [CNT_W-1:0]  t_rowset_q, t_shr_q, t_shs_q, t_conv_q;
  logic              re_busy_q, re_busy_d;
  logic              row_sel_q, row_sel_d;
  logic              sh_r_q, sh_r_d;
  logic              sh_s_q, sh_s_d;
  logic              adc_start_q, adc_start_d;
  logic              row_valid_q, row_valid_d;
  logic              frame_done_q, frame_done_d;

  logic              phase_load;
  logic [CNT_W-1:0]  phase_val;
  logic              phase_tc;

  ro_phase_timer #(.CNT_W(CNT_W)) u_phase_timer (
    .clk        (CLKM),
    .rst_n      (rst_n),
    .load_i     (phase_load),
    .load_val_i (phase_val),
    .tc_o       (phase_tc)
  );

  // State, row address, registered timings and registered outputs.
  always_ff @(posedge CLKM) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      rowadd_q     <= '0;
      t_rowset_q   <= '0;
      t_shr_q      <= '0;
      t_shs_q      <= '0;
      t_conv_q     <= '0;
      re_busy_q    <= 1'b0;
      row_sel_q    <= 1'b0;
      sh_r_q       <= 1'b0;
      sh_s_q       <= 1'b0;
      adc_start_q  <= 1'b0;
      row_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rowadd_q     <= rowadd_d;
      t_rowset_q   <= Trow_set;
      t_shr_q      <= Tshr_w;
      t_shs_q      <= Tshs_w;
      t_conv_q     <= Tconv;
      re_busy_q    <= re_busy_d;
      row_sel_q    <= row_sel_d;
      sh_r_q       <= sh_r_d;
      sh_s_q       <= sh_s_d;
      adc_start_q  <= adc_start_d;
      row_valid_q  <= row_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Next-state decode; also picks the timer reload on entry to a timed phase.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (trigger_i)   state_d = S_ROWSET;
      S_ROWSET: if (phase_tc)    state_d = S_SHR;
      S_SHR:    if (phase_tc)    state_d = S_SHS;
      S_SHS:    if (phase_tc)    state_d = S_CONV;
      S_CONV:   if (phase_tc)    state_d = S_XFER;
      S_XFER:   if (!fifo_afull) state_d = S_NEXT;
      S_NEXT:   state_d = (rowadd_q == LAST_ROW) ? S_DONE : S_ROWSET;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    phase_val = t_rowset_q;
    unique case (state_d)
      S_SHR:   phase_val = t_shr_q;
      S_SHS:   phase_val = t_shs_q;
      S_CONV:  phase_val = t_conv_q;
      default: phase_val = t_rowset_q;
    endcase
    phase_load = (state_d != state_q) &&
                 (state_d inside {S_ROWSET, S_SHR, S_SHS, S_CONV});
  end

  // Output and row-address decode from the next state.
  always_comb begin
    re_busy_d    = (state_d != S_IDLE);
    row_sel_d    = (state_d inside {S_ROWSET, S_SHR, S_SHS});
    sh_r_d       = (state_d == S_SHR);
    sh_s_d       = (state_d == S_SHS);
    adc_start_d  = (state_d == S_CONV) && (state_q != S_CONV);
    row_valid_d  = (state_q == S_XFER) && (state_d == S_NEXT);
    frame_done_d = (state_d == S_DONE);

    rowadd_d = rowadd_q;
    if (state_q == S_DONE) begin
      rowadd_d = '0;
    end else if (state_q == S_NEXT && state_d == S_ROWSET) begin
`ifdef RO_BLACK_ROW_EN
      rowadd_d = (rowadd_q == BLACK_ROW) ? '0 : rowadd_q + ROW_AW'(1);
`else
      rowadd_d = rowadd_q + ROW_AW'(1);
`endif
    end else if (state_q == S_IDLE && state_d == S_ROWSET) begin
`ifdef RO_BLACK_ROW_EN
      rowadd_d = BLACK_ROW;
`else
      rowadd_d = rowadd_q;
`endif
    end
  end

  assign re_busy    = re_busy_q;
  assign RO_ROWADD  = rowadd_q;
  assign ROW_SEL    = row_sel_q;
  assign SH_R       = sh_r_q;
  assign SH_S       = sh_s_q;
  assign ADC_START  = adc_start_q;
  assign row_valid  = row_valid_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_readout_seq_t4.sv
// Directed bench for readout_seq_t4: handshake, frame length, phase widths,
// zero timings, backpressure, mid-frame reset and back-to-back frames.
module tb_readout_seq_t4;

  localparam int NUM_ROW = 320;
  localparam int ROW_AW  = 9;
  localparam int CNT_W   = 32;
`ifdef RO_BLACK_ROW_EN
  localparam int BLACK    = 1;
`else
  localparam int BLACK    = 0;
`endif
  localparam int NROW_EXP = NUM_ROW + BLACK;

  logic              CLKM = 1'b0;
  logic              rst_n = 1'b0;
  logic              trigger_i = 1'b0;
  logic              re_busy;
  logic [ROW_AW-1:0] RO_ROWADD;
  logic              ROW_SEL, SH_R, SH_S, ADC_START, row_valid, frame_done;
  logic              fifo_afull = 1'b0;
  logic [CNT_W-1:0]  Trow_set = '0, Tshr_w = '0, Tshs_w = '0, Tconv = '0;

  int errors = 0;
  int checks = 0;

  readout_seq_t4 #(.NUM_ROW(NUM_ROW), .ROW_AW(ROW_AW), .CNT_W(CNT_W)) dut (
    .CLKM       (CLKM),
    .rst_n      (rst_n),
    .trigger_i  (trigger_i),
    .re_busy    (re_busy),
    .RO_ROWADD  (RO_ROWADD),
    .ROW_SEL    (ROW_SEL),
    .SH_R       (SH_R),
    .SH_S       (SH_S),
    .ADC_START  (ADC_START),
    .row_valid  (row_valid),
    .fifo_afull (fifo_afull),
    .Trow_set   (Trow_set),
    .Tshr_w     (Tshr_w),
    .Tshs_w     (Tshs_w),
    .Tconv      (Tconv),
    .frame_done (frame_done)
  );

  always #5 CLKM = ~CLKM;

  task automatic tick();
    @(posedge CLKM);
    #1;
  endtask

  task automatic do_reset();
    trigger_i  = 1'b0;
    fifo_afull = 1'b0;
    rst_n      = 1'b0;
    tick();
    rst_n      = 1'b1;
    tick();
  endtask

  task automatic set_t(input int a, input int b, input int c, input int d);
    Trow_set = CNT_W'(a);
    Tshr_w   = CNT_W'(b);
    Tshs_w   = CNT_W'(c);
    Tconv    = CNT_W'(d);
    tick();
  endtask

  // Runs from the current cycle to frame_done, counting row_valid pulses and
  // checking the order of row addresses against the expected sequence.
  task automatic run_frame(input int budget, output int nvalid, output int nbad,
                           output bit done_seen);
    int exp_row;
    exp_row   = (BLACK != 0) ? NUM_ROW : 0;
    nvalid    = 0;
    nbad      = 0;
    done_seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (row_valid === 1'b1) begin
        if (int'(RO_ROWADD) != exp_row) nbad++;
        nvalid++;
        exp_row = (exp_row == NUM_ROW) ? 0 : exp_row + 1;
      end
      if (frame_done === 1'b1) begin
        done_seen = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    trigger_i = 1'b1;
    tick();
    tick();
    checks++;
    if (re_busy !== 1'b0 || RO_ROWADD !== '0) begin
      errors++;
      $display("FAIL reset_busy_addr: re_busy=%b addr=%0d expected 0/0", re_busy, RO_ROWADD);
    end
    checks++;
    if ({ROW_SEL, SH_R, SH_S, ADC_START, row_valid, frame_done} !== 6'b0) begin
      errors++;
      $display("FAIL reset_strobes: got %b expected 000000",
               {ROW_SEL, SH_R, SH_S, ADC_START, row_valid, frame_done});
    end
    trigger_i = 1'b0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_handshake_frame();
    int nv, nb;
    bit done;
    set_t(2, 2, 2, 2);
    trigger_i = 1'b1;
    checks++;
    if (re_busy !== 1'b0) begin
      errors++;
      $display("FAIL ack_early: re_busy=%b expected 0", re_busy);
    end
    tick();
    trigger_i = 1'b0;
    checks++;
    if (re_busy !== 1'b1 || ROW_SEL !== 1'b1) begin
      errors++;
      $display("FAIL ack_latency: re_busy=%b row_sel=%b expected 1/1", re_busy, ROW_SEL);
    end
    run_frame(10000, nv, nb, done);
    checks++;
    if (!done || nv != NROW_EXP) begin
      errors++;
      $display("FAIL frame_len: done=%b row_valid=%0d expected 1/%0d", done, nv, NROW_EXP);
    end
    checks++;
    if (nb != 0) begin
      errors++;
      $display("FAIL row_order: %0d rows out of order expected 0", nb);
    end
    checks++;
    if (re_busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_at_done: re_busy=%b expected 1", re_busy);
    end
    tick();
    checks++;
    if (re_busy !== 1'b0 || RO_ROWADD !== '0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL busy_fall: re_busy=%b addr=%0d done=%b expected 0/0/0",
               re_busy, RO_ROWADD, frame_done);
    end
  endtask

  task automatic test_phase_widths();
    int shr_first, shr_n, shs_first, shs_n, adc_first, adc_n, rv_first, sel_n;
    shr_first = -1; shs_first = -1; adc_first = -1; rv_first = -1;
    shr_n = 0; shs_n = 0; adc_n = 0; sel_n = 0;
    set_t(3, 5, 7, 4);
    trigger_i = 1'b1;
    tick();
    trigger_i = 1'b0;
    for (int c = 0; c < 21; c++) begin
      if (SH_R === 1'b1) begin if (shr_first < 0) shr_first = c; shr_n++; end
      if (SH_S === 1'b1) begin if (shs_first < 0) shs_first = c; shs_n++; end
      if (ADC_START === 1'b1) begin if (adc_first < 0) adc_first = c; adc_n++; end
      if (row_valid === 1'b1 && rv_first < 0) rv_first = c;
      if (ROW_SEL === 1'b1) sel_n++;
      tick();
    end
    checks++;
    if (shr_first != 3 || shr_n != 5) begin
      errors++;
      $display("FAIL shr_width: start=%0d len=%0d expected 3/5", shr_first, shr_n);
    end
    checks++;
    if (shs_first != 8 || shs_n != 7) begin
      errors++;
      $display("FAIL shs_width: start=%0d len=%0d expected 8/7", shs_first, shs_n);
    end
    checks++;
    if (adc_first != 15 || adc_n != 1 || sel_n != 15) begin
      errors++;
      $display("FAIL adc_pulse: start=%0d len=%0d row_sel=%0d expected 15/1/15",
               adc_first, adc_n, sel_n);
    end
    checks++;
    if (rv_first != 20) begin
      errors++;
      $display("FAIL row_valid_pos: cycle=%0d expected 20", rv_first);
    end
    checks++;
    if (ROW_SEL !== 1'b1 || int'(RO_ROWADD) != ((BLACK != 0) ? 0 : 1)) begin
      errors++;
      $display("FAIL row_period: row_sel=%b addr=%0d expected 1/%0d",
               ROW_SEL, RO_ROWADD, (BLACK != 0) ? 0 : 1);
    end
    do_reset();
  endtask

  task automatic test_zero_timing();
    int adc_at, rv_at, nv, nb;
    bit done;
    adc_at = -1; rv_at = -1;
    set_t(0, 0, 0, 0);
    trigger_i = 1'b1;
    tick();
    trigger_i = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (ADC_START === 1'b1 && adc_at < 0) adc_at = c;
      if (row_valid === 1'b1 && rv_at < 0) rv_at = c;
      tick();
    end
    checks++;
    if (adc_at != 3 || rv_at != 5) begin
      errors++;
      $display("FAIL zero_phase: adc=%0d row_valid=%0d expected 3/5", adc_at, rv_at);
    end
    run_frame(5000, nv, nb, done);
    checks++;
    if (!done || nv != NROW_EXP - 1) begin
      errors++;
      $display("FAIL zero_frame: done=%b rest_rows=%0d expected 1/%0d", done, nv, NROW_EXP - 1);
    end
    do_reset();
  endtask

  task automatic test_backpressure();
    int early;
    bit found;
    early = 0;
    found = 1'b0;
    set_t(2, 2, 2, 2);
    trigger_i = 1'b1;
    tick();
    trigger_i = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (RO_ROWADD === ROW_AW'(5)) begin found = 1'b1; break; end
      tick();
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL bp_reach_row5: addr=%0d expected 5", RO_ROWADD);
    end
    fifo_afull = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (row_valid === 1'b1) early++;
      tick();
    end
    fifo_afull = 1'b0;
    if (row_valid === 1'b1) early++;
    checks++;
    if (early != 0) begin
      errors++;
      $display("FAIL bp_stall: %0d pulses while full expected 0", early);
    end
    tick();
    checks++;
    if (row_valid !== 1'b1 || RO_ROWADD !== ROW_AW'(5)) begin
      errors++;
      $display("FAIL bp_release: row_valid=%b addr=%0d expected 1/5", row_valid, RO_ROWADD);
    end
    tick();
    checks++;
    if (row_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_single: row_valid=%b expected 0", row_valid);
    end
    do_reset();
  endtask

  task automatic test_reset_mid_frame();
    bit found;
    int busy_n;
    found = 1'b0;
    busy_n = 0;
    set_t(2, 2, 2, 2);
    trigger_i = 1'b1;
    tick();
    trigger_i = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (RO_ROWADD === ROW_AW'(100)) begin found = 1'b1; break; end
      tick();
    end
    checks++;
    if (!found || re_busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_reach_row100: addr=%0d busy=%b expected 100/1", RO_ROWADD, re_busy);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if (re_busy !== 1'b0 || RO_ROWADD !== '0 || ROW_SEL !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: busy=%b addr=%0d row_sel=%b expected 0/0/0",
               re_busy, RO_ROWADD, ROW_SEL);
    end
    for (int c = 0; c < 6; c++) begin
      tick();
      if (re_busy !== 1'b0 || ROW_SEL !== 1'b0) busy_n++;
    end
    checks++;
    if (busy_n != 0) begin
      errors++;
      $display("FAIL rst_stay_idle: %0d active cycles expected 0", busy_n);
    end
  endtask

  task automatic test_back_to_back();
    int nv, nb;
    bit done;
    set_t(0, 0, 0, 0);
    trigger_i = 1'b1;
    tick();
    run_frame(5000, nv, nb, done);
    checks++;
    if (!done || nv != NROW_EXP || nb != 0) begin
      errors++;
      $display("FAIL b2b_frame: done=%b rows=%0d bad=%0d expected 1/%0d/0",
               done, nv, nb, NROW_EXP);
    end
    tick();
    checks++;
    if (re_busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_gap: re_busy=%b expected 0", re_busy);
    end
    tick();
    checks++;
    if (re_busy !== 1'b1 || ROW_SEL !== 1'b1) begin
      errors++;
      $display("FAIL b2b_restart: re_busy=%b row_sel=%b expected 1/1", re_busy, ROW_SEL);
    end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_handshake_frame();
    test_phase_widths();
    test_zero_timing();
    test_backpressure();
    test_reset_mid_frame();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
